// File: rtl/fetch_sequencer.sv
// PC owner and one-entry fetch-to-decode buffer with a valid/ready handshake.
// It applies control-flow redirects and stops fetching once an ebreak has been handed to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ADDR_BITS   = 24,
  parameter logic [31:0] EBREAK_WORD = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT_PEND, HALT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_mask;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        fire;
  logic        slot_free;

  // Keep only word-aligned bits that lie inside the byte-address space.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mask
      assign addr_mask[gi] = (gi >= 2) && (gi < ADDR_BITS);
    end
  endgenerate

  assign pc_plus4        = (pc_reg + 32'd4) & addr_mask;
  assign redirect_target = redirect_pc & addr_mask;
  assign fire            = id_valid & id_ready;
  assign slot_free       = !id_valid | id_ready;
  assign imem_addr       = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      halted      <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          if (redirect_valid) pc_reg <= redirect_target;
          state_reg <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_reg   <= redirect_target;
            id_valid <= 1'b0;
          end else if (slot_free) begin
            id_instr    <= imem_rdata;
            id_pc       <= pc_reg;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            // An ebreak freezes the PC on its own address until it is consumed.
            if (imem_rdata == EBREAK_WORD) state_reg <= HALT_PEND;
            else                           pc_reg    <= pc_plus4;
          end
        end
        HALT_PEND: begin
          if (redirect_valid) begin
            pc_reg    <= redirect_target;
            id_valid  <= 1'b0;
            state_reg <= RUN;
          end else if (fire) begin
            id_valid  <= 1'b0;
            halted    <= 1'b1;
            state_reg <= HALT;
          end
        end
        default: begin
          id_valid <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, ebreak/redirect sequences, wrap instance,
// asynchronous reset, and randomized traffic checked against a stream-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] EB     = 32'h0010_0073;
  localparam logic [31:0] W_RST  = 32'h00FF_FFF8;
  localparam logic [31:0] NO_EB  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc_plus4;
  logic        redirect_valid, id_valid, id_ready, halted;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_plus4;
  logic        w_valid, w_halted;
  logic [31:0] ebreak_addr = NO_EB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] base_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return 32'h1300_0000 ^ a;
  endfunction

  function automatic logic [31:0] wrap24(input logic [31:0] a);
    return a % 32'h0100_0000;
  endfunction

  assign imem_rdata = (imem_addr == ebreak_addr) ? EB : base_word(imem_addr);
  assign w_rdata    = base_word(w_addr);

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .halted(halted)
  );

  fetch_sequencer #(.RESET_PC(W_RST)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr),
    .id_pc(w_pc), .id_pc_plus4(w_pc_plus4), .halted(w_halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc_plus4", id_pc_plus4, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_w_addr", w_addr, W_RST);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[13];

  task automatic run_table();
    logic [31:0] wexp;
    ebreak_addr = NO_EB;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      id_ready = tbl[i].ready;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      @(negedge clk);
      $display("row %0d valid=%0d pc=%h addr=%h", i, id_valid, id_pc, imem_addr);
      chk($sformatf("t%0d_valid", i), 32'(id_valid), 32'(tbl[i].ev));
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("t%0d_halted", i), 32'(halted), 32'h0);
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_pc", i), id_pc, tbl[i].epc);
        chk($sformatf("t%0d_instr", i), id_instr, base_word(tbl[i].epc));
        chk($sformatf("t%0d_plus4", i), id_pc_plus4, tbl[i].epc + 32'd4);
      end
      if (i >= 1 && i <= 3) begin
        wexp = wrap24(W_RST + 32'(4 * (i - 1)));
        chk($sformatf("w%0d_pc", i), w_pc, wexp);
        chk($sformatf("w%0d_plus4", i), w_pc_plus4, wrap24(wexp + 32'd4));
        chk($sformatf("w%0d_addr", i), w_addr, wrap24(wexp + 32'd4));
        chk($sformatf("w%0d_valid", i), 32'(w_valid), 32'h1);
      end
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
  endtask

  task automatic wait_pc10(output bit found);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (id_valid && id_pc == 32'h10) found = 1'b1;
    end
    chk("ebreak_presented", 32'(found), 32'h1);
  endtask

  // Stream-level reference: the instruction being presented and the next address to fetch.
  bit          m_boot, m_halt, m_pv;
  logic [31:0] m_ppc, m_next;

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    return (a == ebreak_addr) ? EB : base_word(a);
  endfunction

  initial begin
    bit found;
    logic r, v;
    logic [31:0] t;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'hC};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'hC};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'hC};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'hC};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  32'h14};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'h14};
    tbl[10] = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   32'h100};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h108};

    run_table();

    // Asynchronous reset between edges, then an identical restart.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(id_valid), 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_pc", id_pc, 32'h0);
    chk("async_halted", 32'(halted), 32'h0);
    run_table();

    // Ebreak accepted: halt, then redirects ignored.
    ebreak_addr = 32'h10;
    do_reset();
    id_ready = 1'b1;
    wait_pc10(found);
    chk("eb_instr", id_instr, EB);
    chk("eb_halted_before", 32'(halted), 32'h0);
    @(negedge clk);
    chk("eb_halted_after", 32'(halted), 32'h1);
    chk("eb_valid_after", 32'(id_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("halt_redir_halted", 32'(halted), 32'h1);
    chk("halt_redir_valid", 32'(id_valid), 32'h0);
    chk("halt_redir_addr", imem_addr, 32'h10);
    @(negedge clk);
    chk("halt_hold_valid", 32'(id_valid), 32'h0);

    // Ebreak held unaccepted, then redirected away.
    do_reset();
    id_ready = 1'b1;
    wait_pc10(found);
    id_ready = 1'b0;
    @(negedge clk);
    chk("ebh_valid", 32'(id_valid), 32'h1);
    chk("ebh_pc", id_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("ebr_valid", 32'(id_valid), 32'h0);
    chk("ebr_addr", imem_addr, 32'h40);
    chk("ebr_halted", 32'(halted), 32'h0);
    id_ready = 1'b1;
    @(negedge clk);
    chk("ebr_next_valid", 32'(id_valid), 32'h1);
    chk("ebr_next_pc", id_pc, 32'h40);
    chk("ebr_next_halted", 32'(halted), 32'h0);

    // Randomized traffic against the reference model.
    for (int run = 0; run < 4; run++) begin
      ebreak_addr = (run == 3) ? NO_EB : 32'h20 + 32'(run * 24);
      do_reset();
      m_boot = 1'b1; m_halt = 1'b0; m_pv = 1'b0; m_ppc = 32'h0; m_next = 32'h0;
      for (int c = 0; c < 200; c++) begin
        chk("rnd_valid", 32'(id_valid), 32'(m_pv));
        chk("rnd_halted", 32'(halted), 32'(m_halt));
        chk("rnd_addr", imem_addr, m_next);
        if (m_pv) begin
          chk("rnd_pc", id_pc, m_ppc);
          chk("rnd_instr", id_instr, model_mem(m_ppc));
          chk("rnd_plus4", id_pc_plus4, wrap24(m_ppc + 32'd4));
        end
        r = ($urandom_range(0, 3) != 0);
        v = ($urandom_range(0, 9) == 0);
        t = {$urandom_range(0, 255) & 32'hFF, 24'h0} | ($urandom_range(0, 127));
        if (m_pv && r && !v && !m_boot && !m_halt)
          $display("fire run=%0d pc=%h instr=%h", run, m_ppc, model_mem(m_ppc));
        if (m_halt) begin
        end else if (m_boot) begin
          m_boot = 1'b0;
          if (v) m_next = t & 32'h00FF_FFFC;
        end else if (v) begin
          m_pv = 1'b0;
          m_next = t & 32'h00FF_FFFC;
        end else if (m_pv && model_mem(m_ppc) == EB) begin
          if (r) begin
            m_pv = 1'b0;
            m_halt = 1'b1;
          end
        end else if (!m_pv || r) begin
          m_pv = 1'b1;
          m_ppc = m_next;
          if (model_mem(m_next) != EB) m_next = wrap24(m_next + 32'd4);
        end
        id_ready = r;
        redirect_valid = v;
        redirect_pc = t;
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-to-decode buffer stage sitting directly upstream of the combinational instruction memory and downstream-feeding the decoder. Owns the PC, drives the instruction-memory byte address, captures the returned word into a one-entry output register with a valid/ready handshake to decode, and applies control-flow redirects. Halts fetching on `ebreak` so simulation and the Logisim image agree on end-of-program.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; low 2 bits must be zero.
- `ADDR_BITS`, 24: byte-address width; PC arithmetic is modulo 2^ADDR_BITS, upper bits always zero.
- `EBREAK_WORD`, 32'h0010_0073: encoding that triggers halt.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `imem_addr` out 32: byte address to instruction memory; equals the PC register.
- `imem_rdata` in 32: word returned combinationally for `imem_addr`.
- `redirect_valid` in 1: take `redirect_pc` this cycle.
- `redirect_pc` in 32: redirect target; bits [1:0] and bits above ADDR_BITS are cleared on load.
- `id_valid` out 1: output register holds an instruction for decode.
- `id_ready` in 1: decode accepts this cycle.
- `id_instr` out 32: captured instruction.
- `id_pc` out 32: address of `id_instr`.
- `id_pc_plus4` out 32: `id_pc`+4 modulo 2^ADDR_BITS.
- `halted` out 1: `ebreak` has been handed to decode; fetch stopped.

## Operation
- States: BOOT, RUN, HALT_PEND, HALT.
- Reset (async): pc=RESET_PC, state=BOOT, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, halted=0.
- BOOT: one cycle, no capture; next state RUN.
- Fire = id_valid & id_ready. Slot free = !id_valid | id_ready.
- RUN, no redirect, slot free: capture imem_rdata -> id_instr, pc -> id_pc, pc+4 -> id_pc_plus4; id_valid<=1; pc<=pc+4. If captured word == EBREAK_WORD: pc holds, state<=HALT_PEND.
- RUN, no redirect, slot not free (id_valid & !id_ready): all registers hold; imem_addr stable.
- Redirect (RUN or HALT_PEND): highest priority. pc<=masked redirect_pc; id_valid<=0 (held or would-be-captured instruction is discarded; if Fire occurs same cycle the presented instruction counts as consumed); state<=RUN. No capture that cycle.
- HALT_PEND: no capture, pc holds. When Fire on the ebreak: id_valid<=0, state<=HALT, halted<=1.
- HALT: all outputs frozen, id_valid=0, halted=1; redirect_valid ignored. Exit only via rst.
- Redirect in BOOT: loads pc, state<=RUN.
- PC wrap: pc 2^ADDR_BITS-4 advances to 0; id_pc_plus4 wraps identically.

## Timing
- imem_addr combinational from pc register; instruction captured on the rising edge ending the cycle it is addressed.
- First id_valid: rising edge ending the second cycle after rst deasserts (BOOT, then capture at RESET_PC).
- Throughput: 1 instruction/cycle with id_ready held high.
- Redirect latency: redirect_valid sampled at edge N; imem_addr=target during cycle N+1; target instruction valid after edge N+1, no bubble beyond the discarded slot.
- Backpressure: id_instr/id_pc/id_valid stable while id_valid & !id_ready.
- halted asserts on the edge where the ebreak fires.
- rst asserted mid-stream: outputs reach reset values immediately (asynchronously), independent of clk.

## Test plan
- Reset, memory 0..: 0x00500093, 0x00100113, id_ready=1 -> id_valid rises after 2nd edge, id_pc sequence 0x0,0x4,0x8 on consecutive cycles, id_pc_plus4 = id_pc+4.
- Stream with id_ready low 3 cycles at id_pc=0x8 -> id_instr/id_pc held 3 cycles, imem_addr stays 0xC, resumes with id_pc=0xC, no loss or duplicate.
- redirect_valid with redirect_pc=0x0000_0103 during a stall -> held instruction dropped, next id_pc=0x100, imem_addr=0x100 next cycle.
- EBREAK at 0x10, id_ready=1 -> ebreak presented with id_pc=0x10, halted=1 after it fires, id_valid=0 thereafter, later redirects ignored; repeat with redirect to 0x40 while ebreak held unaccepted -> returns to RUN, id_pc=0x40, halted stays 0.
- RESET_PC=0x00FF_FFF8 -> id_pc 0xFFFFF8, 0xFFFFFC, 0x000000; id_pc_plus4 at 0xFFFFFC is 0x0.
- rst asserted between clock edges mid-stream -> id_valid=0, pc=RESET_PC immediately; restart identical to first scenario.
